multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter: MEM_TIMEOUT, default 255, maximum consecutive MemReady-low wait cycles tolerated in any memory state; 1..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 Opcode  input  6  instruction bits [31:26] from the instruction register.
REQ-005 MemReady  input  1  memory completion handshake for the current access.
REQ-006 PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, ALUSrcA, RegWrite, RegDst  output  1 each  datapath controls.
REQ-007 ALUSrcB, ALUOp, PCSource  output  2 each  datapath selects; ALUOp is 0 for add, 1 for subtract/beq, 2 for funct-decoded.
REQ-008 LoadSize  output  2  0 for word, 1 for lh, 2 for lhu; valid in MEMRD and MEMWB.
REQ-009 IllegalOp, MemTimeout  output  1 each  single-cycle error pulses.
REQ-010 State  output  4  current state encoding, for debug.

Function
REQ-011 Block SHALL be a registered Moore FSM; outputs decode from the state, except IRWrite/PCWrite in FETCH, which SHALL equal MemReady.
REQ-012 Outputs not listed for a state SHALL be 0, except MemtoReg=1 (1 selects ALU result; 0 selects memory data).
REQ-013 State encodings SHALL be FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RTYPEWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10; codes 11-15 SHALL go to FETCH on the next edge.
REQ-014 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=0, PCSource=0; hold while MemReady=0; go to DECODE when MemReady=1.
REQ-015 DECODE: ALUSrcB=3, ALUOp=0; next state by Opcode: 0x00 -> EXEC, 0x04 -> BRANCH, 0x08 -> ADDIEX, 0x23/0x2B -> MEMADR, otherwise FETCH with IllegalOp=1 this cycle.
REQ-016 MEMADR: ALUSrcA=1, ALUSrcB=2, ALUOp=0; next state MEMWR for 0x2B, else MEMRD.
REQ-017 MEMRD: MemRead=1, IorD=1; hold until MemReady=1, then MEMWB.
REQ-018 MEMWB: RegWrite=1, MemtoReg=0, RegDst=0 -> FETCH.
REQ-019 MEMWR: MemWrite=1, IorD=1; hold until MemReady=1, then FETCH.
REQ-020 EXEC: ALUSrcA=1, ALUSrcB=0, ALUOp=2 -> RTYPEWB; RTYPEWB: RegDst=1, RegWrite=1 -> FETCH.
REQ-021 BRANCH: ALUSrcA=1, ALUSrcB=0, ALUOp=1, PCWriteCond=1, PCSource=1 -> FETCH.
REQ-022 ADDIEX: ALUSrcA=1, ALUSrcB=2, ALUOp=0 -> ADDIWB; ADDIWB: RegWrite=1, RegDst=0 -> FETCH.
REQ-023 Cycle counts SHALL be, with zero wait: R-type 4, addi 4, beq 3, sw 4, lw 5; each MemReady-low cycle adds one.
REQ-024 An 8-bit wait counter SHALL clear on entry to FETCH/MEMRD/MEMWR and increment each cycle MemReady=0 in those states.
REQ-025 When the counter reaches MEM_TIMEOUT with MemReady still 0, FSM SHALL go to FETCH, MemTimeout SHALL pulse for that cycle, and no write enable SHALL assert.
REQ-026 MemReady=1 in the same cycle the counter reaches MEM_TIMEOUT SHALL complete normally without MemTimeout.

Reset
REQ-027 reset=1 SHALL force FETCH and clear the wait counter on the next edge, including mid-wait, with error pulses and all enables deasserted.
REQ-028 While reset=1, outputs SHALL show FETCH decode with IRWrite/PCWrite forced to 0.

Configuration
REQ-029 With MC_HALFWORD_EN defined, opcodes 0x21 (lh) and 0x25 (lhu) SHALL follow the lw path with LoadSize 1 and 2 respectively.
REQ-030 Without MC_HALFWORD_EN, 0x21/0x25 SHALL be illegal (REQ-015) and LoadSize SHALL be tied to 0.

Structure
REQ-031 A shared package SHALL hold the state encodings, opcode constants, and ALUOp/ALUSrcB/PCSource codes.
REQ-032 One sub-module, mc_wait_timer (counter plus compare), is natural; next-state and output decode stay in the top.

Verification
REQ-033 Opcode 0x00, MemReady=1 -> states 0,1,6,7,0; RegWrite and RegDst=1 only in cycle 4.
REQ-034 lw (0x23), MemReady low for 3 cycles in MEMRD -> MEMRD held 4 cycles; MEMWB has MemtoReg=0, RegWrite=1.
REQ-035 Opcode 0x3F -> DECODE pulses IllegalOp for 1 cycle; next state FETCH; no write enable asserts.
REQ-036 MEM_TIMEOUT=4, MemReady held 0 in MEMWR -> after 4 wait cycles, MemTimeout pulses and state goes to 0.
REQ-037 reset asserted in MEMRD during a wait -> next state 0, counter 0, MemRead with IorD=0.
REQ-038 0x25 with and without MC_HALFWORD_EN -> LoadSize=2 in MEMRD when defined; IllegalOp pulse when undefined.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: states, opcodes and datapath select codes.
// The MC_HALFWORD_EN macro (see top) enables the lh/lhu load-size decode helper below.
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        ST_FETCH   = 4'd0,
        ST_DECODE  = 4'd1,
        ST_MEMADR  = 4'd2,
        ST_MEMRD   = 4'd3,
        ST_MEMWB   = 4'd4,
        ST_MEMWR   = 4'd5,
        ST_EXEC    = 4'd6,
        ST_RTYPEWB = 4'd7,
        ST_BRANCH  = 4'd8,
        ST_ADDIEX  = 4'd9,
        ST_ADDIWB  = 4'd10
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [1:0] ALUOP_ADD   = 2'd0;
    localparam logic [1:0] ALUOP_SUB   = 2'd1;
    localparam logic [1:0] ALUOP_FUNCT = 2'd2;

    localparam logic [1:0] SRCB_REG   = 2'd0;
    localparam logic [1:0] SRCB_FOUR  = 2'd1;
    localparam logic [1:0] SRCB_IMM   = 2'd2;
    localparam logic [1:0] SRCB_IMMSH = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;

    localparam logic [1:0] LS_WORD = 2'd0;
    localparam logic [1:0] LS_LH   = 2'd1;
    localparam logic [1:0] LS_LHU  = 2'd2;

    function automatic logic [1:0] load_size(input logic [5:0] op);
        case (op)
            OP_LH:   return LS_LH;
            OP_LHU:  return LS_LHU;
            default: return LS_WORD;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_wait_timer.sv
// Memory wait counter: counts MemReady-low cycles in a memory state and flags when
// the tolerated number of wait cycles has been used up.
module mc_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic inc_i,
    output logic expired_o
);

    localparam logic [7:0] LIMIT = 8'(MEM_TIMEOUT);

    logic [7:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i)
            count_d = '0;
        else if (inc_i)
            count_d = count_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign expired_o = (count_q == LIMIT);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control unit: Moore FSM with memory wait timeout.
// Define MC_HALFWORD_EN to route lh/lhu through the load path with LoadSize set.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Opcode,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       ALUSrcA,
    output logic       RegWrite,
    output logic       RegDst,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic [1:0] LoadSize,
    output logic       IllegalOp,
    output logic       MemTimeout,
    output logic [3:0] State
);

    state_t state_q, state_d, dec_st;
    logic   in_wait, expired, timeout;

    assign in_wait = (state_q == ST_FETCH) || (state_q == ST_MEMRD) || (state_q == ST_MEMWR);
    assign timeout = !reset && in_wait && !MemReady && expired;

    // Any state change (or a timeout back into FETCH) is an entry that restarts the count.
    mc_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (timeout || (state_d != state_q)),
        .inc_i     (in_wait && !MemReady && !timeout),
        .expired_o (expired)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= ST_FETCH;
        else
            state_q <= state_d;
    end

    assign State      = state_q;
    assign MemTimeout = timeout;
    assign dec_st     = reset ? ST_FETCH : state_q;

    always_comb begin
        state_d     = ST_FETCH;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b1;
        ALUSrcA     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        ALUSrcB     = SRCB_REG;
        ALUOp       = ALUOP_ADD;
        PCSource    = PCSRC_ALU;
        LoadSize    = LS_WORD;
        IllegalOp   = 1'b0;

        case (dec_st)
            ST_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                IRWrite = MemReady;
                PCWrite = MemReady;
                state_d = MemReady ? ST_DECODE : ST_FETCH;
            end
            ST_DECODE: begin
                ALUSrcB = SRCB_IMMSH;
                case (Opcode)
                    OP_RTYPE:     state_d = ST_EXEC;
                    OP_BEQ:       state_d = ST_BRANCH;
                    OP_ADDI:      state_d = ST_ADDIEX;
                    OP_LW, OP_SW: state_d = ST_MEMADR;
`ifdef MC_HALFWORD_EN
                    OP_LH, OP_LHU: state_d = ST_MEMADR;
`endif
                    default:      IllegalOp = 1'b1;
                endcase
            end
            ST_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                state_d = (Opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
            end
            ST_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                state_d = MemReady ? ST_MEMWB : ST_MEMRD;
            end
            ST_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b0;
            end
            ST_MEMWR: begin
                MemWrite = !timeout;
                IorD     = 1'b1;
                state_d  = MemReady ? ST_FETCH : ST_MEMWR;
            end
            ST_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_FUNCT;
                state_d = ST_RTYPEWB;
            end
            ST_RTYPEWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            ST_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALUOP_SUB;
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
            end
            ST_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                state_d = ST_ADDIWB;
            end
            ST_ADDIWB: begin
                RegWrite = 1'b1;
            end
            default: ;
        endcase

`ifdef MC_HALFWORD_EN
        if (dec_st == ST_MEMRD || dec_st == ST_MEMWB)
            LoadSize = load_size(Opcode);
`endif

        if (timeout)
            state_d = ST_FETCH;
        if (reset) begin
            IRWrite = 1'b0;
            PCWrite = 1'b0;
            state_d = ST_FETCH;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control (MEM_TIMEOUT=4): state sequences, wait/timeout, reset, illegal ops.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] Opcode;
    logic       MemReady;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg;
    logic       ALUSrcA, RegWrite, RegDst, IllegalOp, MemTimeout;
    logic [1:0] ALUSrcB, ALUOp, PCSource, LoadSize;
    logic [3:0] State;

    int n_asrt = 0;
    int n_fail = 0;

    multicycle_control #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .MemReady(MemReady),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
        .RegWrite(RegWrite), .RegDst(RegDst), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .LoadSize(LoadSize), .IllegalOp(IllegalOp),
        .MemTimeout(MemTimeout), .State(State)
    );

    always #5 clk = ~clk;

    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,ALUSrcA,RegWrite,RegDst,ALUSrcB,ALUOp,PCSource}
    logic [15:0] ctl;
    assign ctl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                  ALUSrcA, RegWrite, RegDst, ALUSrcB, ALUOp, PCSource};

    localparam logic [15:0] C_F1     = 16'b1001011000_01_00_00;
    localparam logic [15:0] C_F0     = 16'b0001001000_01_00_00;
    localparam logic [15:0] C_DEC    = 16'b0000001000_11_00_00;
    localparam logic [15:0] C_MEMADR = 16'b0000001100_10_00_00;
    localparam logic [15:0] C_MEMRD  = 16'b0011001000_00_00_00;
    localparam logic [15:0] C_MEMWB  = 16'b0000000010_00_00_00;
    localparam logic [15:0] C_MEMWR  = 16'b0010101000_00_00_00;
    localparam logic [15:0] C_WR_TO  = 16'b0010001000_00_00_00;
    localparam logic [15:0] C_EXEC   = 16'b0000001100_00_10_00;
    localparam logic [15:0] C_RTWB   = 16'b0000001011_00_00_00;
    localparam logic [15:0] C_BRANCH = 16'b0100001100_00_01_01;
    localparam logic [15:0] C_ADDIEX = 16'b0000001100_10_00_00;
    localparam logic [15:0] C_ADDIWB = 16'b0000001010_00_00_00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_asrt++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs are already applied; check this cycle's outputs, then advance one clock.
    task automatic cyc(input string tag, input logic [3:0] st, input logic [15:0] c,
                       input logic ill, input logic to, input logic [1:0] ls);
        #1;
        chk({tag, ".state"}, 32'(State), 32'(st));
        chk({tag, ".ctl"}, 32'(ctl), 32'(c));
        chk({tag, ".illegal"}, 32'(IllegalOp), 32'(ill));
        chk({tag, ".timeout"}, 32'(MemTimeout), 32'(to));
        chk({tag, ".loadsize"}, 32'(LoadSize), 32'(ls));
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; MemReady = 1'b0; Opcode = 6'h00;
        @(posedge clk); #1;
        MemReady = 1'b1;
        cyc("reset_hold", 4'd0, C_F0, 0, 0, 0);
        reset = 1'b0;

        // R-type, zero wait: 0,1,6,7
        Opcode = 6'h00;
        cyc("rt0", 4'd0, C_F1, 0, 0, 0);
        cyc("rt1", 4'd1, C_DEC, 0, 0, 0);
        cyc("rt2", 4'd6, C_EXEC, 0, 0, 0);
        cyc("rt3", 4'd7, C_RTWB, 0, 0, 0);

        // lw with three wait cycles in MEMRD
        Opcode = 6'h23;
        cyc("lw0", 4'd0, C_F1, 0, 0, 0);
        cyc("lw1", 4'd1, C_DEC, 0, 0, 0);
        cyc("lw2", 4'd2, C_MEMADR, 0, 0, 0);
        MemReady = 1'b0;
        cyc("lw3", 4'd3, C_MEMRD, 0, 0, 0);
        cyc("lw4", 4'd3, C_MEMRD, 0, 0, 0);
        cyc("lw5", 4'd3, C_MEMRD, 0, 0, 0);
        MemReady = 1'b1;
        cyc("lw6", 4'd3, C_MEMRD, 0, 0, 0);
        cyc("lw7", 4'd4, C_MEMWB, 0, 0, 0);

        Opcode = 6'h04;
        cyc("beq0", 4'd0, C_F1, 0, 0, 0);
        cyc("beq1", 4'd1, C_DEC, 0, 0, 0);
        cyc("beq2", 4'd8, C_BRANCH, 0, 0, 0);

        // addi with two wait cycles in FETCH
        Opcode = 6'h08; MemReady = 1'b0;
        cyc("addi0", 4'd0, C_F0, 0, 0, 0);
        cyc("addi1", 4'd0, C_F0, 0, 0, 0);
        MemReady = 1'b1;
        cyc("addi2", 4'd0, C_F1, 0, 0, 0);
        cyc("addi3", 4'd1, C_DEC, 0, 0, 0);
        cyc("addi4", 4'd9, C_ADDIEX, 0, 0, 0);
        cyc("addi5", 4'd10, C_ADDIWB, 0, 0, 0);

        Opcode = 6'h2B;
        cyc("sw0", 4'd0, C_F1, 0, 0, 0);
        cyc("sw1", 4'd1, C_DEC, 0, 0, 0);
        cyc("sw2", 4'd2, C_MEMADR, 0, 0, 0);
        cyc("sw3", 4'd5, C_MEMWR, 0, 0, 0);

        Opcode = 6'h3F;
        cyc("ill0", 4'd0, C_F1, 0, 0, 0);
        cyc("ill1", 4'd1, C_DEC, 1, 0, 0);

        // sw timeout: four tolerated waits, fifth low cycle times out
        Opcode = 6'h2B;
        cyc("swto0", 4'd0, C_F1, 0, 0, 0);
        cyc("swto1", 4'd1, C_DEC, 0, 0, 0);
        cyc("swto2", 4'd2, C_MEMADR, 0, 0, 0);
        MemReady = 1'b0;
        for (int i = 0; i < 4; i++) cyc("swto_w", 4'd5, C_MEMWR, 0, 0, 0);
        cyc("swto_exp", 4'd5, C_WR_TO, 0, 1, 0);
        cyc("swto_after", 4'd0, C_F0, 0, 0, 0);
        MemReady = 1'b1;

        // sw where MemReady rises exactly at the limit: normal completion
        cyc("swlim0", 4'd0, C_F1, 0, 0, 0);
        cyc("swlim1", 4'd1, C_DEC, 0, 0, 0);
        cyc("swlim2", 4'd2, C_MEMADR, 0, 0, 0);
        MemReady = 1'b0;
        for (int i = 0; i < 4; i++) cyc("swlim_w", 4'd5, C_MEMWR, 0, 0, 0);
        MemReady = 1'b1;
        cyc("swlim_ok", 4'd5, C_MEMWR, 0, 0, 0);

        // FETCH timeout then recovery
        Opcode = 6'h04; MemReady = 1'b0;
        cyc("fto_pre", 4'd0, C_F0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc("fto_w", 4'd0, C_F0, 0, 0, 0);
        cyc("fto_exp", 4'd0, C_F0, 0, 1, 0);
        MemReady = 1'b1;
        cyc("fto_rec", 4'd0, C_F1, 0, 0, 0);
        cyc("fto_dec", 4'd1, C_DEC, 0, 0, 0);
        cyc("fto_br", 4'd8, C_BRANCH, 0, 0, 0);

        // lhu
        Opcode = 6'h25;
        cyc("lhu0", 4'd0, C_F1, 0, 0, 0);
`ifdef MC_HALFWORD_EN
        cyc("lhu1", 4'd1, C_DEC, 0, 0, 0);
        cyc("lhu2", 4'd2, C_MEMADR, 0, 0, 0);
        cyc("lhu3", 4'd3, C_MEMRD, 0, 0, 2);
        cyc("lhu4", 4'd4, C_MEMWB, 0, 0, 2);
`else
        cyc("lhu1", 4'd1, C_DEC, 1, 0, 0);
`endif

        // reset mid-wait in MEMRD
        Opcode = 6'h23;
        cyc("rw0", 4'd0, C_F1, 0, 0, 0);
        cyc("rw1", 4'd1, C_DEC, 0, 0, 0);
        cyc("rw2", 4'd2, C_MEMADR, 0, 0, 0);
        MemReady = 1'b0;
        cyc("rw3", 4'd3, C_MEMRD, 0, 0, 0);
        cyc("rw4", 4'd3, C_MEMRD, 0, 0, 0);
        reset = 1'b1;
        cyc("rw_rst", 4'd3, C_F0, 0, 0, 0);
        reset = 1'b0;
        // Cleared counter: four more low cycles must not time out
        for (int i = 0; i < 4; i++) cyc("rw_post", 4'd0, C_F0, 0, 0, 0);
        MemReady = 1'b1;
        cyc("rw_f1", 4'd0, C_F1, 0, 0, 0);
        cyc("rw_dec", 4'd1, C_DEC, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
